// File: rtl/issue_queue.sv
// Instruction buffer between IF and ID/EX with an oldest-first dual-issue selector.
// Latency: a pushed entry is visible at the issue slots the cycle after the push edge; slots are combinational from storage.
// Backpressure: in_ready drops when fewer than two entries are free; out_ready=0 holds the head and freezes the slots.
module issue_queue #(
    parameter int DEPTH   = 8,
    parameter int PC_W    = 32,
    parameter int LS_PAIR = 0,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [1:0]               in_cnt,
    input  logic [31:0]              in_inst0,
    input  logic [31:0]              in_inst1,
    input  logic [PC_W-1:0]          in_pc0,
    input  logic [PC_W-1:0]          in_pc1,
    output logic                     in_ready,
    input  logic                     out_ready,
    output logic                     out_valid0,
    output logic                     out_valid1,
    output logic [31:0]              out_inst0,
    output logic [31:0]              out_inst1,
    output logic [PC_W-1:0]          out_pc0,
    output logic [PC_W-1:0]          out_pc1,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         dual_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]     inst_mem [DEPTH];
    logic [PC_W-1:0] pc_mem   [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW-1:0]   head1;
    logic [AW-1:0]   tail1;
    logic [1:0]      push_n;
    logic [1:0]      pop_n;
    logic            single0;
    logic            single1;
    logic            dep;
    logic [4:0]      dest0;
    logic [4:0]      dest1;

    // Loads and stores occupy opcodes 0x20..0x2B.
    function automatic logic is_mem(input logic [5:0] op);
        return (op >= 6'h20) && (op <= 6'h2B);
    endfunction

    // Instructions that must issue alone: mult/div, hi/lo moves, all control flow, memory ops.
    function automatic logic is_single(input logic [5:0] op, input logic [5:0] fn);
        logic s;
        s = 1'b0;
        if (op == 6'h00)
            s = (fn == 6'h08) || (fn == 6'h09) ||
                ((fn >= 6'h10) && (fn <= 6'h13)) ||
                ((fn >= 6'h18) && (fn <= 6'h1B));
        else if ((op >= 6'h01) && (op <= 6'h07))
            s = 1'b1;
        else if (is_mem(op))
            s = 1'b1;
        return s;
    endfunction

    // Register written by the instruction; 0 means no architectural destination.
    function automatic logic [4:0] dest_of(input logic [5:0] op, input logic [4:0] rt,
                                           input logic [4:0] rd);
        logic [4:0] d;
        d = 5'd0;
        if (op == 6'h00)
            d = rd;
        else if (((op >= 6'h08) && (op <= 6'h0F)) || ((op >= 6'h20) && (op <= 6'h27)))
            d = rt;
        return d;
    endfunction

    assign head1      = head + AW'(1);
    assign tail1      = tail + AW'(1);
    assign out_inst0  = inst_mem[head];
    assign out_inst1  = inst_mem[head1];
    assign out_pc0    = pc_mem[head];
    assign out_pc1    = pc_mem[head1];
    assign in_ready   = (count <= (AW+1)'(DEPTH - 2));
    assign out_valid0 = (count != '0);

    // Pairing decision for the two oldest entries; rs/rt of slot 1 are compared unconditionally.
    always_comb begin
        single0 = is_single(out_inst0[31:26], out_inst0[5:0]);
        single1 = is_single(out_inst1[31:26], out_inst1[5:0]);
        if ((LS_PAIR != 0) && is_mem(out_inst0[31:26]) && !is_mem(out_inst1[31:26]))
            single0 = 1'b0;
        dest0 = dest_of(out_inst0[31:26], out_inst0[20:16], out_inst0[15:11]);
        dest1 = dest_of(out_inst1[31:26], out_inst1[20:16], out_inst1[15:11]);
        dep   = (dest0 != 5'd0) &&
                ((dest0 == out_inst1[25:21]) || (dest0 == out_inst1[20:16]) || (dest0 == dest1));
        out_valid1 = (count > (AW+1)'(1)) && !single0 && !single1 && !dep;
    end

    // Accepted push and pop counts for this edge; illegal in_cnt=3 counts as no push.
    always_comb begin
        push_n = 2'd0;
        if (in_ready && !flush && ((in_cnt == 2'd1) || (in_cnt == 2'd2)))
            push_n = in_cnt;
        pop_n = 2'd0;
        if (out_ready)
            pop_n = {1'b0, out_valid0} + {1'b0, out_valid1};
    end

    // Entry storage; deliberately not reset, only pointers define validity.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) begin
            inst_mem[tail] <= in_inst0;
            pc_mem[tail]   <= in_pc0;
        end
        if (push_n == 2'd2) begin
            inst_mem[tail1] <= in_inst1;
            pc_mem[tail1]   <= in_pc1;
        end
    end

    // Head/tail/occupancy; flush empties the buffer and drops same-cycle traffic.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_n);
            tail  <= tail + AW'(push_n);
            count <= count + (AW+1)'(push_n) - (AW+1)'(pop_n);
        end
    end

    // Saturating count of dual-issue cycles; survives flush, and a flushed cycle issues nothing.
    always_ff @(posedge clk) begin
        if (rst)
            dual_cnt <= '0;
        else if (out_ready && out_valid1 && !flush && (dual_cnt != {CNT_W{1'b1}}))
            dual_cnt <= dual_cnt + CNT_W'(1);
    end
endmodule
